imem_boot_loader: RTL



---
 rtl/boot_pkg.sv | 16 +
 rtl/byte_assembler.sv | 48 ++++
 rtl/imem_boot_loader.sv | 115 +++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package boot_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int INSTR_WIDTH    = 32;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        PAYLOAD,
        CHECK,
        DONE,
        ERROR
    } boot_state_e;

endpackage

// File: rtl/byte_assembler.sv
// Packs accepted payload bytes little-endian into 32-bit instruction words.
module byte_assembler
    import boot_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    output logic                   word_valid,
    output logic [INSTR_WIDTH-1:0] word
);

    logic [1:0]  idx_q, idx_d;
    logic [23:0] low_q, low_d;

    always_comb begin
        idx_d = idx_q;
        low_d = low_q;
        if (clear) begin
            idx_d = '0;
            low_d = '0;
        end else if (byte_valid) begin
            idx_d = idx_q + 2'd1;
            case (idx_q)
                2'd0:    low_d[7:0]   = byte_data;
                2'd1:    low_d[15:8]  = byte_data;
                2'd2:    low_d[23:16] = byte_data;
                default: low_d        = low_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= '0;
            low_q <= '0;
        end else begin
            idx_q <= idx_d;
            low_q <= low_d;
        end
    end

    // The fourth byte completes the word straight from the input, no extra cycle.
    assign word_valid = byte_valid && !clear && (idx_q == 2'd3);
    assign word       = {byte_data, low_q};

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a framed, XOR-checked byte stream into instruction memory and holds the core in reset until it verifies.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    MAX_WORDS  = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   imem_we,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    output logic [INSTR_WIDTH-1:0] imem_wdata,
    output logic                   cpu_reset,
    output logic                   done,
    output logic                   error,
    output boot_state_e            state_dbg
);

    // Byte transfer: a byte moves on a rising edge where in_valid && in_ready; no backpressure beyond in_ready.
    boot_state_e            state_q, state_d;
    logic                   accept, asm_valid, asm_clear, word_valid, last_word, oversize;
    logic [INSTR_WIDTH-1:0] word;
    logic [15:0]            len_w, len_q, word_cnt_q;
    logic [7:0]             len_lo_q, csum_q;
    logic [ADDR_WIDTH-1:0]  next_addr_q, imem_addr_q;
    logic [INSTR_WIDTH-1:0] imem_wdata_q;
    logic                   imem_we_q, done_q, error_q, cpu_reset_q;

    assign len_w     = {in_data, len_lo_q};
    assign oversize  = {16'd0, len_w} > 32'(MAX_WORDS);
    assign last_word = (word_cnt_q == len_q - 16'd1);

    always_ff @(posedge clk) begin
        if (reset) state_q <= LEN_LO;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                LEN_LO:  state_d = LEN_HI;
                LEN_HI: begin
                    if (len_w == 16'd0) state_d = CHECK;
                    else if (oversize)  state_d = ERROR;
                    else                state_d = PAYLOAD;
                end
                PAYLOAD: if (word_valid && last_word) state_d = CHECK;
                CHECK:   state_d = (in_data == csum_q) ? DONE : ERROR;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        in_ready  = !reset && (state_q inside {LEN_LO, LEN_HI, PAYLOAD, CHECK});
        accept    = in_valid && in_ready;
        asm_valid = accept && (state_q == PAYLOAD);
        asm_clear = reset || (state_q != PAYLOAD);
    end

    byte_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (asm_clear),
        .byte_valid (asm_valid),
        .byte_data  (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            len_lo_q     <= '0;
            len_q        <= '0;
            csum_q       <= '0;
            word_cnt_q   <= '0;
            next_addr_q  <= BASE_ADDR;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE_ADDR;
            imem_wdata_q <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_reset_q  <= 1'b1;
        end else begin
            imem_we_q <= word_valid;
            // The check byte itself is excluded from the running XOR.
            if (accept && state_q != CHECK) csum_q <= csum_q ^ in_data;
            if (accept && state_q == LEN_LO) len_lo_q <= in_data;
            if (accept && state_q == LEN_HI) len_q <= len_w;
            if (word_valid) begin
                imem_addr_q  <= next_addr_q;
                imem_wdata_q <= word;
                next_addr_q  <= next_addr_q + ADDR_WIDTH'(BYTES_PER_WORD);
                word_cnt_q   <= word_cnt_q + 16'd1;
            end
            done_q      <= (state_d == DONE);
            error_q     <= (state_d == ERROR);
            cpu_reset_q <= (state_d != DONE);
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign done       = done_q;
    assign error      = error_q;
    assign cpu_reset  = cpu_reset_q;
    assign state_dbg  = state_q;

endmodule
